square_wave_period_detector: RTL and testbench

- Measuring counterpart to the discrete square-wave oscillators: takes a signed 16-bit audio sample stream and recovers a clean logic level using a hysteresis (Schmitt) comparator.
- Measures period and high-time, in samples, between successive rising crossings.
- Sits on the discrete-audio sample bus and is clocked with the same audio_clk_en strobe.
- Used for self-check and calibration of oscillator models, and for driving frequency-dependent logic from analog-modelled signals.

---
 rtl/square_wave_period_detector.sv | 207 ++++++++++++++++++++
 tb/tb_square_wave_period_detector.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/square_wave_period_detector.sv
// Schmitt-trigger square-wave detector measuring period and high-time between rising crossings.
// Define PERIOD_AVG_EN to report the mean of the last four periods instead of single values.
module square_wave_period_detector #(
    parameter int          THRESHOLD_HIGH     = 12288,
    parameter int          THRESHOLD_LOW      = 4096,
    parameter int unsigned MAX_PERIOD_SAMPLES = 65535
) (
    input  logic        clk,
    input  logic        I_RST,
    input  logic        audio_clk_en,
    input  logic [15:0] in,
    output logic        level,
    output logic [15:0] period_samples,
    output logic [15:0] high_samples,
    output logic        period_valid,
    output logic        locked,
    output logic        timeout
);

    localparam logic signed [15:0] ThrHigh  = THRESHOLD_HIGH[15:0];
    localparam logic signed [15:0] ThrLow   = THRESHOLD_LOW[15:0];
    localparam logic        [15:0] MaxCount = MAX_PERIOD_SAMPLES[15:0];

    typedef enum logic [1:0] {
        StIdle,
        StHigh,
        StLow
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] count_q, count_d;
    logic [15:0] high_latch_q, high_latch_d;
    logic [15:0] period_q, period_d;
    logic [15:0] high_q, high_d;
    logic        level_q, level_d;
    logic        valid_q, valid_d;
    logic        locked_q, locked_d;
    logic        timeout_q, timeout_d;

    logic signed [15:0] sample;
    logic               rise;
    logic               fall;
    logic [15:0]        count_inc;
    logic               capture;
    logic               expire;

    assign sample    = in;
    assign rise      = audio_clk_en && !level_q && (sample >= ThrHigh);
    assign fall      = audio_clk_en && level_q && (sample <= ThrLow);
    // count stays below MaxCount, so the increment cannot overflow
    assign count_inc = count_q + 16'd1;

`ifdef PERIOD_AVG_EN
    logic [3:0][15:0] per_hist_q;
    logic [3:0][15:0] high_hist_q;
    logic [2:0]       fill_q;
    logic [17:0]      per_sum;
    logic [17:0]      high_sum;
    logic [15:0]      period_avg;
    logic [15:0]      high_avg;

    // Sums include the sample being captured this strobe plus the three newest stored.
    always_comb begin
        per_sum    = {2'b00, count_inc} + {2'b00, per_hist_q[0]}
                   + {2'b00, per_hist_q[1]} + {2'b00, per_hist_q[2]};
        high_sum   = {2'b00, high_latch_q} + {2'b00, high_hist_q[0]}
                   + {2'b00, high_hist_q[1]} + {2'b00, high_hist_q[2]};
        period_avg = per_sum[17:2];
        high_avg   = high_sum[17:2];
    end

    always_ff @(posedge clk or posedge I_RST) begin
        if (I_RST) begin
            per_hist_q  <= '0;
            high_hist_q <= '0;
            fill_q      <= 3'd0;
        end else if (expire) begin
            per_hist_q  <= '0;
            high_hist_q <= '0;
            fill_q      <= 3'd0;
        end else if (capture) begin
            per_hist_q  <= {per_hist_q[2:0], count_inc};
            high_hist_q <= {high_hist_q[2:0], high_latch_q};
            if (fill_q != 3'd4) begin
                fill_q <= fill_q + 3'd1;
            end
        end
    end
`endif

    always_comb begin
        level_d = level_q;
        if (rise) begin
            level_d = 1'b1;
        end else if (fall) begin
            level_d = 1'b0;
        end
    end

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        high_latch_d = high_latch_q;
        period_d     = period_q;
        high_d       = high_q;
        valid_d      = 1'b0;
        locked_d     = locked_q;
        timeout_d    = 1'b0;
        capture      = 1'b0;
        expire       = 1'b0;

        if (audio_clk_en) begin
            unique case (state_q)
                StIdle: begin
                    count_d = '0;
                    if (rise) begin
                        state_d = StHigh;
                    end
                end
                StHigh: begin
                    if (count_inc == MaxCount) begin
                        expire = 1'b1;
                    end else begin
                        count_d = count_inc;
                        if (fall) begin
                            state_d      = StLow;
                            high_latch_d = count_inc;
                        end
                    end
                end
                StLow: begin
                    // A crossing on the timeout strobe still completes the period.
                    if (rise) begin
                        capture = 1'b1;
                        count_d = '0;
                        state_d = StHigh;
                    end else if (count_inc == MaxCount) begin
                        expire = 1'b1;
                    end else begin
                        count_d = count_inc;
                    end
                end
                default: begin
                    state_d = StIdle;
                    count_d = '0;
                end
            endcase
        end

        if (expire) begin
            state_d   = StIdle;
            count_d   = '0;
            timeout_d = 1'b1;
            locked_d  = 1'b0;
            period_d  = '0;
            high_d    = '0;
        end

        if (capture) begin
`ifdef PERIOD_AVG_EN
            if (fill_q >= 3'd3) begin
                period_d = period_avg;
                high_d   = high_avg;
                valid_d  = 1'b1;
                locked_d = 1'b1;
            end
`else
            period_d = count_inc;
            high_d   = high_latch_q;
            valid_d  = 1'b1;
            locked_d = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk or posedge I_RST) begin
        if (I_RST) begin
            state_q      <= StIdle;
            count_q      <= '0;
            high_latch_q <= '0;
            period_q     <= '0;
            high_q       <= '0;
            level_q      <= 1'b0;
            valid_q      <= 1'b0;
            locked_q     <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            high_latch_q <= high_latch_d;
            period_q     <= period_d;
            high_q       <= high_d;
            level_q      <= level_d;
            valid_q      <= valid_d;
            locked_q     <= locked_d;
            timeout_q    <= timeout_d;
        end
    end

    assign level          = level_q;
    assign period_samples = period_q;
    assign high_samples   = high_q;
    assign period_valid   = valid_q;
    assign locked         = locked_q;
    assign timeout        = timeout_q;

endmodule

// File: tb/tb_square_wave_period_detector.sv
// Bench for square_wave_period_detector: vector table, corner sequences and randomized
// waveforms checked against a crossing-timestamp reference model.
module tb_square_wave_period_detector;

    localparam int TH   = 12288;
    localparam int TL   = 4096;
    localparam int MAXP = 100;

    logic        clk = 1'b0;
    logic        I_RST;
    logic        audio_clk_en;
    logic [15:0] in_s;
    logic        level;
    logic [15:0] period_samples;
    logic [15:0] high_samples;
    logic        period_valid;
    logic        locked;
    logic        timeout;

    always #5 clk = ~clk;

    square_wave_period_detector #(
        .THRESHOLD_HIGH    (TH),
        .THRESHOLD_LOW     (TL),
        .MAX_PERIOD_SAMPLES(MAXP)
    ) dut (
        .clk           (clk),
        .I_RST         (I_RST),
        .audio_clk_en  (audio_clk_en),
        .in            (in_s),
        .level         (level),
        .period_samples(period_samples),
        .high_samples  (high_samples),
        .period_valid  (period_valid),
        .locked        (locked),
        .timeout       (timeout)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: timestamps (in strobes) of the last rising and falling crossings.
    bit m_level, m_meas, m_valid, m_locked, m_to;
    int m_sidx, m_trise, m_tfall, m_per, m_high;
    int hist_p[$];
    int hist_h[$];

    function automatic logic [35:0] pack(logic l, logic v, logic k, logic t,
                                         logic [15:0] p, logic [15:0] h);
        return {l, v, k, t, p, h};
    endfunction

    function automatic logic [35:0] dut_pack();
        return pack(level, period_valid, locked, timeout, period_samples, high_samples);
    endfunction

    task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (lvl,vld,lck,to,per,high)", name, act, exp);
    endtask

    function automatic void model_reset();
        m_level = 0; m_meas = 0; m_valid = 0; m_locked = 0; m_to = 0;
        m_per = 0; m_high = 0; m_trise = 0; m_tfall = 0;
        hist_p.delete();
        hist_h.delete();
    endfunction

    function automatic void model_capture(int p, int h);
`ifdef PERIOD_AVG_EN
        int sp, sh;
        hist_p.push_back(p);
        hist_h.push_back(h);
        if (hist_p.size() > 4) begin
            void'(hist_p.pop_front());
            void'(hist_h.pop_front());
        end
        if (hist_p.size() == 4) begin
            sp = 0; sh = 0;
            for (int i = 0; i < 4; i++) begin
                sp += hist_p[i];
                sh += hist_h[i];
            end
            m_valid = 1; m_locked = 1; m_per = sp / 4; m_high = sh / 4;
        end
`else
        m_valid = 1; m_locked = 1; m_per = p; m_high = h;
`endif
    endfunction

    function automatic void model_step(bit s, int x);
        bit rise, fall;
        m_valid = 0;
        m_to = 0;
        if (!s) return;
        m_sidx++;
        rise = !m_level && (x >= TH);
        fall = m_level && (x <= TL);
        if (rise) m_level = 1;
        else if (fall) m_level = 0;
        if (m_meas) begin
            if (rise) begin
                model_capture(m_sidx - m_trise, m_tfall - m_trise);
                m_trise = m_sidx;
            end else if (m_sidx - m_trise == MAXP) begin
                m_to = 1; m_meas = 0; m_locked = 0; m_per = 0; m_high = 0;
                hist_p.delete();
                hist_h.delete();
            end else if (fall) begin
                m_tfall = m_sidx;
            end
        end else if (rise) begin
            m_meas = 1;
            m_trise = m_sidx;
        end
    endfunction

    function automatic logic [35:0] model_pack();
        return pack(m_level, m_valid, m_locked, m_to, 16'(m_per), 16'(m_high));
    endfunction

    task automatic step(input logic s, input int x);
        audio_clk_en = s;
        in_s = 16'(x);
        @(posedge clk);
        #1;
        model_step(s, x);
        check("model", dut_pack(), model_pack());
    endtask

    task automatic do_reset();
        audio_clk_en = 0;
        I_RST = 1;
        model_reset();
        @(posedge clk);
        #1;
        I_RST = 0;
    endtask

    task automatic square(input int h, input int l);
        for (int i = 0; i < h; i++) step(1, 16384);
        for (int i = 0; i < l; i++) step(1, 0);
    endtask

    function automatic int rnd(int lo, int hi);
        return lo + int'($urandom_range(0, hi - lo));
    endfunction

    typedef struct {
        logic        s;
        int          x;
        logic        lvl;
        logic        vld;
        logic [15:0] per;
        logic [15:0] hi;
        logic        lck;
        logic        to;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(int n, logic s, int x, logic lvl, logic vld,
                                logic [15:0] per, logic [15:0] hi, logic lck);
        vec_t v;
        v = '{s: s, x: x, lvl: lvl, vld: vld, per: per, hi: hi, lck: lck, to: 1'b0};
        for (int i = 0; i < n; i++) tbl.push_back(v);
    endfunction

    initial begin
        bit any_level, any_valid, any_to;
        int hl, ll;

        // 5 high + 5 low, then 3 high + 7 low, then noise while high, then threshold edges
        add(5, 1, 16384, 1, 0, 0, 0, 0);
        add(1, 1, 0, 0, 0, 0, 0, 0);
        add(1, 0, 16384, 0, 0, 0, 0, 0);
        add(4, 1, 0, 0, 0, 0, 0, 0);
        add(1, 1, 16384, 1, 1, 10, 5, 1);
        add(1, 0, 0, 1, 0, 10, 5, 1);
        add(2, 1, 16384, 1, 0, 10, 5, 1);
        add(7, 1, 0, 0, 0, 10, 5, 1);
        add(1, 1, 16384, 1, 1, 10, 3, 1);
        add(1, 1, 11000, 1, 0, 10, 3, 1);
        add(1, 1, 5000, 1, 0, 10, 3, 1);
        add(1, 1, 8000, 1, 0, 10, 3, 1);
        add(1, 1, 4097, 1, 0, 10, 3, 1);
        add(1, 1, 4096, 0, 0, 10, 3, 1);
        add(1, 1, 12288, 1, 1, 6, 5, 1);

        I_RST = 1;
        audio_clk_en = 0;
        in_s = 0;
        model_reset();
        m_sidx = 0;
        #12;
        check("reset_state", dut_pack(), 36'd0);
        @(posedge clk);
        #1;
        I_RST = 0;

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].s, tbl[i].x);
`ifndef PERIOD_AVG_EN
            check($sformatf("vec[%0d]", i), dut_pack(),
                  pack(tbl[i].lvl, tbl[i].vld, tbl[i].lck, tbl[i].to, tbl[i].per, tbl[i].hi));
`endif
        end

        // Constant high after lock: timeout exactly MAXP strobes after the last rise
        for (int k = 1; k <= MAXP; k++) begin
            step(1, 16384);
            if (k == MAXP - 1) check("timeout_early", {35'd0, timeout}, 36'd0);
        end
        check("timeout", dut_pack(), pack(1, 0, 0, 1, 0, 0));
        step(0, 16384);
        check("timeout_pulse_width", {35'd0, timeout}, 36'd0);

        // Relock, then async reset mid-HIGH without a clock edge
        step(1, 0);
        square(5, 5);
        square(5, 5);
        square(5, 5);
        step(1, 16384);
        step(1, 16384);
        audio_clk_en = 0;
        I_RST = 1;
        #1;
        check("async_reset", dut_pack(), 36'd0);
        model_reset();
        @(posedge clk);
        #1;
        I_RST = 0;

        // Ramps that never reach the high threshold: no level, no valid, no timeout
        any_level = 0; any_valid = 0; any_to = 0;
        for (int r = 0; r < 4; r++) begin
            for (int v = 0; v <= 20; v++) begin
                step(1, v * 500);
                any_level |= level; any_valid |= period_valid; any_to |= timeout;
            end
            for (int v = 19; v >= 1; v--) begin
                step(1, v * 500);
                any_level |= level; any_valid |= period_valid; any_to |= timeout;
            end
        end
        check("ramp_no_activity", {33'd0, any_level, any_valid, any_to}, 36'd0);

        // After reset, a valid needs two rising crossings
        step(1, 16384);
        check("first_rise_no_valid", {35'd0, period_valid}, 36'd0);
        for (int i = 0; i < 4; i++) step(1, 16384);
        for (int i = 0; i < 5; i++) step(1, 0);
        step(1, 16384);
`ifndef PERIOD_AVG_EN
        check("second_rise_valid", dut_pack(), pack(1, 1, 1, 0, 10, 5));
`else
        check("second_rise_avg_pending", dut_pack(), pack(1, 0, 0, 0, 0, 0));
`endif

`ifdef PERIOD_AVG_EN
        // Periods 10,10,12,12: first valid after the fourth, mean 11 / high mean 5
        do_reset();
        square(5, 5);
        square(5, 5);
        square(6, 6);
        step(1, 16384);
        check("avg_not_ready", {35'd0, period_valid}, 36'd0);
        for (int i = 0; i < 5; i++) step(1, 16384);
        for (int i = 0; i < 6; i++) step(1, 0);
        step(1, 16384);
        check("avg_first_valid", dut_pack(), pack(1, 1, 1, 0, 11, 5));
`endif

        // Randomized waveforms with noise, exact-threshold samples and idle cycles
        do_reset();
        for (int seg = 0; seg < 60; seg++) begin
            hl = rnd(1, 40);
            ll = rnd(1, 40);
            if ($urandom_range(0, 9) == 0) hl = rnd(MAXP - 5, MAXP + 10);
            if ($urandom_range(0, 9) == 0) ll = rnd(MAXP - 5, MAXP + 10);
            for (int i = 0; i < hl; i++) begin
                if ($urandom_range(0, 3) == 0) step(0, rnd(-32768, 32767));
                if (i == 0) step(1, ($urandom_range(0, 3) == 0) ? TH : rnd(TH, 32767));
                else step(1, rnd(TL + 1, 32767));
            end
            for (int i = 0; i < ll; i++) begin
                if ($urandom_range(0, 3) == 0) step(0, rnd(-32768, 32767));
                if (i == 0) step(1, ($urandom_range(0, 3) == 0) ? TL : rnd(-32768, TL));
                else step(1, rnd(-32768, TH - 1));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
